video_rd_ctrl: RTL
==================

// Module: video_rd_ctrl
// PURPOSE
// - AXI4 read master for display path: fetches stored video frames from DDR (MIG1 UI domain), one
//   full line per burst, into the display line buffer. Counterpart of the video write control;
//   same address map: [13:0] byte in line (3840x4B), [25:14] line, [27:26] frame, [31:28] base.
// - Reads the frame one behind the writer's current frame; starts only when VIDEO_DISP_EN=1.
// PARAMETERS
// - P_SIM        1'b0  1: short lines/frames for simulation
// - P_DEVICE_ID  4'h1  ARID value
// - P_AXIM_DLEN  P_SIM?8'd15:8'd239  ARLEN (beats per line - 1, 64B beats)
// - P_VLINES     P_SIM?12'd60:12'd2160  lines per frame
// PORTS
// - CLK_MIG1_UI        in   1    MIG ui_clk, only clock
// - RST                in   1    synchronous reset, active-high
// - REG_VACT_EN_MIG1   in   1    video active enable
// - VIDEO_DISP_EN      in   1    display enable from write control
// - VIDEO_RX_FRM_WCNT  in   2    frame currently being written
// - DISP_SOF           in   1    display start-of-frame pulse
// - DISP_LBUF_RDY      in   1    line buffer can accept one full line
// - DISP_LBUF_WEN      out  1    line buffer write enable (one per beat)
// - DISP_LBUF_WD       out  512  line buffer write data
// - DISP_LBUF_WCMP     out  1    one-cycle pulse: line complete
// - VIDEO_AXIM_AR*     out  -    ARID4 ARADDR32 ARLEN8 ARSIZE3 ARBURST2 ARLOCK1 ARCACHE4 ARPROT3 ARQOS4 ARVALID1
// - VIDEO_AXIM_ARREADY in   1    read address ready
// - VIDEO_AXIM_RID/RDATA/RRESP/RLAST/RVALID  in  4/512/2/1/1  read data channel
// - VIDEO_AXIM_RREADY  out  1    read data ready
// - RD_ERR             out  1    sticky: RRESP!=OKAY or RLAST misplaced
// - RD_ERR_CNT         out  16   error beat count (see CONFIGURATION)
// BEHAVIOUR
// - Reset: FSM=IDLE, address=0, line cnt=0, all outputs 0 except constant AR fields.
// - Constants: ARSIZE=3'b110, ARBURST=INCR, ARCACHE=4'h3, ARLOCK/ARPROT/ARQOS=0, ARLEN=P_AXIM_DLEN.
// - DISP_SOF (while enabled and DISP_EN): latch read frame = VIDEO_RX_FRM_WCNT-1 (mod 4), line=0,
//   frame active=1. SOF during a burst: latched into pending; applied at END.
// - FSM one-hot: IDLE -> AINF when active & DISP_LBUF_RDY & line<P_VLINES; AINF -> AVLD (ARADDR
//   registered); AVLD holds ARVALID until ARREADY, then DATA; DATA: RREADY=1, each RVALID beat
//   -> DISP_LBUF_WEN=1, WD=RDATA same cycle (combinational, zero latency); on RVALID&RLAST -> END;
//   END: DISP_LBUF_WCMP=1 for 1 cycle, line+1 -> IDLE.
// - ARADDR/line count are stable while ARVALID=1 (AXI rule); no outstanding burst >1.
// - Line == P_VLINES: frame done, stays IDLE until next DISP_SOF; no wrap of line field.
// - Beat counter: RLAST expected on beat P_AXIM_DLEN; early/late RLAST sets RD_ERR; FSM always
//   exits DATA on RLAST (never hangs), missing beats not padded.
// - REG_VACT_EN_MIG1=0 or VIDEO_DISP_EN=0: no new AINF; current burst drains to END; then
//   address/frame active cleared; RD_ERR cleared only by RST or REG_VACT_EN_MIG1 0->1.
// - RID ignored (single ID). RST mid-burst: FSM to IDLE immediately; interconnect reset together.
// CONFIGURATION
// - VIDEO_RD_ERR_CNT_EN defined: RD_ERR_CNT counts beats with RRESP!=0 plus RLAST faults,
//   saturating at 16'hFFFF, cleared like RD_ERR.
// - Undefined: RD_ERR_CNT tied 16'h0; RD_ERR still implemented.
// STRUCTURE
// - video_axi_pkg: FSM state encodings, address field bounds (H 13:0, V 25:14, F 27:26), AXI
//   constants (SIZE_64B, BURST_INCR, CACHE, RESP_OKAY), line/beat defaults.
// - One sub-module: video_rd_addr_gen (frame latch, line counter, ARADDR compose, frame-done).
// - FSM, beat check, error logic in top.
// TESTING
// - P_SIM=1, WCNT=2, SOF, LBUF_RDY=1, ARREADY=1 -> ARADDR 0x0400_0000(frame1,line0), 16 WEN, WCMP.
// - Full frame: 60 bursts, ARADDR[25:14]=0..59, then no AR until next SOF; WCNT=0 -> frame 3.
// - ARREADY held 0 for 10 cycles -> ARVALID/ARADDR stable; RVALID gaps -> WEN only on valid beats.
// - RLAST on beat 10 -> FSM to END, RD_ERR=1; RRESP=2'b10 x3 -> RD_ERR_CNT=3 (macro defined), 0 if not.
// - DISP_EN dropped mid-burst -> burst completes, WCMP pulses, no further AR; RST mid-burst -> IDLE, outputs 0.

Source files
------------

// File: rtl/video_axi_pkg.sv
// rtl/video_axi_pkg.sv - shared constants for the video AXI read path
package video_axi_pkg;

  localparam logic [4:0] ST_IDLE = 5'b00001;
  localparam logic [4:0] ST_AINF = 5'b00010;
  localparam logic [4:0] ST_AVLD = 5'b00100;
  localparam logic [4:0] ST_DATA = 5'b01000;
  localparam logic [4:0] ST_END  = 5'b10000;

  localparam int H_LSB = 0;
  localparam int H_MSB = 13;
  localparam int V_LSB = 14;
  localparam int V_MSB = 25;
  localparam int F_LSB = 26;
  localparam int F_MSB = 27;

  localparam logic [2:0] SIZE_64B   = 3'b110;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] AR_CACHE   = 4'h3;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] ADDR_BASE  = 4'h0;

  localparam logic [7:0]  DLEN_SIM    = 8'd15;
  localparam logic [7:0]  DLEN_FULL   = 8'd239;
  localparam logic [11:0] VLINES_SIM  = 12'd60;
  localparam logic [11:0] VLINES_FULL = 12'd2160;

  // Lines always start at byte 0, so the horizontal field is zero.
  function automatic logic [31:0] compose_addr(input logic [1:0] frame, input logic [11:0] line);
    logic [31:0] a;
    a = '0;
    a[H_MSB:H_LSB] = '0;
    a[V_MSB:V_LSB] = line;
    a[F_MSB:F_LSB] = frame;
    a[31:28]       = ADDR_BASE;
    return a;
  endfunction

endpackage

// File: rtl/video_rd_addr_gen.sv
// rtl/video_rd_addr_gen.sv - read frame latch, line counter and ARADDR compose
module video_rd_addr_gen
  import video_axi_pkg::*;
#(
  parameter logic [11:0] P_VLINES = VLINES_FULL
) (
  input  logic        CLK_MIG1_UI,
  input  logic        RST,
  input  logic        sof,
  input  logic        busy,
  input  logic        clear,
  input  logic        load,
  input  logic        line_end,
  input  logic [1:0]  wcnt,
  output logic        active,
  output logic        frame_done,
  output logic [31:0] araddr
);

  logic [1:0]  frame;
  logic [1:0]  pend_frame;
  logic [1:0]  sof_frame;
  logic [11:0] line;
  logic        pend;

  assign sof_frame = wcnt - 2'd1;

  // A start-of-frame seen mid-burst is parked and takes effect when the line closes.
  always_ff @(posedge CLK_MIG1_UI) begin
    if (RST || clear) begin
      frame      <= '0;
      pend_frame <= '0;
      line       <= '0;
      pend       <= 1'b0;
      active     <= 1'b0;
      araddr     <= '0;
    end else begin
      if (load) araddr <= compose_addr(frame, line);
      if (sof && !busy) begin
        frame  <= sof_frame;
        line   <= '0;
        active <= 1'b1;
      end else if (line_end) begin
        if (pend || sof) begin
          frame  <= sof ? sof_frame : pend_frame;
          line   <= '0;
          active <= 1'b1;
          pend   <= 1'b0;
        end else begin
          line <= line + 12'd1;
        end
      end else if (sof) begin
        pend       <= 1'b1;
        pend_frame <= sof_frame;
      end
    end
  end

  assign frame_done = (line >= P_VLINES);

endmodule

// File: rtl/video_rd_ctrl.sv
// rtl/video_rd_ctrl.sv - AXI4 line-burst read master for the display path (VIDEO_RD_ERR_CNT_EN enables error counter)
module video_rd_ctrl
  import video_axi_pkg::*;
#(
  parameter logic        P_SIM       = 1'b0,
  parameter logic [3:0]  P_DEVICE_ID = 4'h1,
  parameter logic [7:0]  P_AXIM_DLEN = P_SIM ? DLEN_SIM : DLEN_FULL,
  parameter logic [11:0] P_VLINES    = P_SIM ? VLINES_SIM : VLINES_FULL
) (
  input  logic         CLK_MIG1_UI,
  input  logic         RST,
  input  logic         REG_VACT_EN_MIG1,
  input  logic         VIDEO_DISP_EN,
  input  logic [1:0]   VIDEO_RX_FRM_WCNT,
  input  logic         DISP_SOF,
  input  logic         DISP_LBUF_RDY,
  output logic         DISP_LBUF_WEN,
  output logic [511:0] DISP_LBUF_WD,
  output logic         DISP_LBUF_WCMP,
  output logic [3:0]   VIDEO_AXIM_ARID,
  output logic [31:0]  VIDEO_AXIM_ARADDR,
  output logic [7:0]   VIDEO_AXIM_ARLEN,
  output logic [2:0]   VIDEO_AXIM_ARSIZE,
  output logic [1:0]   VIDEO_AXIM_ARBURST,
  output logic         VIDEO_AXIM_ARLOCK,
  output logic [3:0]   VIDEO_AXIM_ARCACHE,
  output logic [2:0]   VIDEO_AXIM_ARPROT,
  output logic [3:0]   VIDEO_AXIM_ARQOS,
  output logic         VIDEO_AXIM_ARVALID,
  input  logic         VIDEO_AXIM_ARREADY,
  input  logic [3:0]   VIDEO_AXIM_RID,
  input  logic [511:0] VIDEO_AXIM_RDATA,
  input  logic [1:0]   VIDEO_AXIM_RRESP,
  input  logic         VIDEO_AXIM_RLAST,
  input  logic         VIDEO_AXIM_RVALID,
  output logic         VIDEO_AXIM_RREADY,
  output logic         RD_ERR,
  output logic [15:0]  RD_ERR_CNT
);

  logic [4:0] state;
  logic [7:0] beat_cnt;
  logic       run_en;
  logic       frm_active;
  logic       frame_done;
  logic       data_beat;
  logic       last_fault;
  logic       resp_fault;
  logic       vact_d;
  logic       err_clr;
  logic       rd_err;
  logic       unused_rid;

  assign unused_rid = ^VIDEO_AXIM_RID;
  assign run_en     = REG_VACT_EN_MIG1 & VIDEO_DISP_EN;
  assign data_beat  = (state == ST_DATA) & VIDEO_AXIM_RVALID;
  assign resp_fault = data_beat & (VIDEO_AXIM_RRESP != RESP_OKAY);
  assign last_fault = data_beat & (VIDEO_AXIM_RLAST ? (beat_cnt != P_AXIM_DLEN)
                                                    : (beat_cnt == P_AXIM_DLEN));
  assign err_clr    = REG_VACT_EN_MIG1 & ~vact_d;

  video_rd_addr_gen #(.P_VLINES(P_VLINES)) u_addr_gen (
    .CLK_MIG1_UI (CLK_MIG1_UI),
    .RST         (RST),
    .sof         (DISP_SOF & run_en),
    .busy        (state != ST_IDLE),
    .clear       (~run_en & (state == ST_IDLE)),
    .load        (state == ST_AINF),
    .line_end    (state == ST_END),
    .wcnt        (VIDEO_RX_FRM_WCNT),
    .active      (frm_active),
    .frame_done  (frame_done),
    .araddr      (VIDEO_AXIM_ARADDR)
  );

  // DATA always leaves on RLAST, whatever the beat count, so a bad slave cannot hang us.
  always_ff @(posedge CLK_MIG1_UI) begin
    if (RST) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (run_en && frm_active && DISP_LBUF_RDY && !frame_done) state <= ST_AINF;
        ST_AINF: state <= ST_AVLD;
        ST_AVLD: begin
          beat_cnt <= '0;
          if (VIDEO_AXIM_ARREADY) state <= ST_DATA;
        end
        ST_DATA: if (VIDEO_AXIM_RVALID) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (VIDEO_AXIM_RLAST) state <= ST_END;
        end
        ST_END:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_MIG1_UI) begin
    if (RST) begin
      vact_d <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      vact_d <= REG_VACT_EN_MIG1;
      if (err_clr)                       rd_err <= 1'b0;
      else if (resp_fault || last_fault) rd_err <= 1'b1;
    end
  end

`ifdef VIDEO_RD_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign err_inc = {1'b0, resp_fault} + {1'b0, last_fault};
  assign err_sum = {1'b0, err_cnt} + {15'h0, err_inc};

  always_ff @(posedge CLK_MIG1_UI) begin
    if (RST || err_clr)  err_cnt <= '0;
    else if (err_sum[16]) err_cnt <= 16'hFFFF;
    else                  err_cnt <= err_sum[15:0];
  end

  assign RD_ERR_CNT = err_cnt;
`else
  assign RD_ERR_CNT = 16'h0;
`endif

  assign RD_ERR             = rd_err;
  assign DISP_LBUF_WEN      = data_beat;
  assign DISP_LBUF_WD       = data_beat ? VIDEO_AXIM_RDATA : '0;
  assign DISP_LBUF_WCMP     = (state == ST_END);
  assign VIDEO_AXIM_ARVALID = (state == ST_AVLD);
  assign VIDEO_AXIM_RREADY  = (state == ST_DATA);

  assign VIDEO_AXIM_ARID    = P_DEVICE_ID;
  assign VIDEO_AXIM_ARLEN   = P_AXIM_DLEN;
  assign VIDEO_AXIM_ARSIZE  = SIZE_64B;
  assign VIDEO_AXIM_ARBURST = BURST_INCR;
  assign VIDEO_AXIM_ARLOCK  = 1'b0;
  assign VIDEO_AXIM_ARCACHE = AR_CACHE;
  assign VIDEO_AXIM_ARPROT  = 3'b000;
  assign VIDEO_AXIM_ARQOS   = 4'h0;

endmodule
